// File: rtl/mult_arbiter.sv
// Round-robin share of one combinational multiplier between NUM_REQ lanes.
// Flow per transaction: accept operands (IDLE) -> sample product (CALC) -> hand back (RESP).

module mult_arbiter_lane #(
  parameter int PTR_W = 2,
  parameter int LANE  = 0
) (
  input  logic             accept_en,
  input  logic [PTR_W-1:0] grant_idx,
  input  logic             resp_en,
  input  logic [PTR_W-1:0] owner,
  output logic             req_ready,
  output logic             rsp_valid
);
  assign req_ready = accept_en && (grant_idx == PTR_W'(LANE));
  assign rsp_valid = resp_en && (owner == PTR_W'(LANE));
endmodule

module mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int COUNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_x,
  input  logic [NUM_REQ*DATA_W-1:0] req_y,
  output logic [DATA_W-1:0]         mul_x,
  output logic [DATA_W-1:0]         mul_y,
  input  logic [DATA_W-1:0]         mul_result,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy,
  output logic [COUNT_W-1:0]        op_count
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [DATA_W-1:0]  op_x_q, op_x_d;
  logic [DATA_W-1:0]  op_y_q, op_y_d;
  logic [DATA_W-1:0]  res_q, res_d;
  logic [COUNT_W-1:0] op_count_q, op_count_d;

  logic               grant_found;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   scan_idx;
  logic               accept_en;
  logic               resp_en;

  // Walk from farthest to nearest so the lane closest after rr_ptr wins last.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scan_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Gated by rst so no lane sees an accept while the block is held in reset.
  assign accept_en = (state_q == IDLE) && grant_found && !rst;
  assign resp_en   = (state_q == RESP);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    mult_arbiter_lane #(.PTR_W(PTR_W), .LANE(i)) u_lane (
      .accept_en (accept_en),
      .grant_idx (grant_idx),
      .resp_en   (resp_en),
      .owner     (owner_q),
      .req_ready (req_ready[i]),
      .rsp_valid (rsp_valid[i])
    );
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    op_x_d     = op_x_q;
    op_y_d     = op_y_q;
    res_d      = res_q;
    op_count_d = op_count_q;
    unique case (state_q)
      IDLE: if (accept_en) begin
        op_x_d   = req_x[int'(grant_idx)*DATA_W +: DATA_W];
        op_y_d   = req_y[int'(grant_idx)*DATA_W +: DATA_W];
        owner_d  = grant_idx;
        rr_ptr_d = grant_idx;
        state_d  = CALC;
      end
      CALC: begin
        res_d   = mul_result;
        state_d = RESP;
      end
      RESP: if (rsp_ready[owner_q]) begin
        op_count_d = op_count_q + COUNT_W'(1);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= PTR_W'(NUM_REQ - 1);
      owner_q    <= '0;
      op_x_q     <= '0;
      op_y_q     <= '0;
      res_q      <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      op_x_q     <= op_x_d;
      op_y_q     <= op_y_d;
      res_q      <= res_d;
      op_count_q <= op_count_d;
    end
  end

  assign mul_x    = op_x_q;
  assign mul_y    = op_y_q;
  assign rsp_data = res_q;
  assign busy     = (state_q != IDLE);
  assign op_count = op_count_q;
endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed vector table, corner-case sequences, and random
// traffic checked against a transaction-level round-robin / scoreboard model.

module tb_mult_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   rsp_ready = '0;
  logic [N*W-1:0] req_x = '0;
  logic [N*W-1:0] req_y = '0;

  logic [N-1:0] req_ready, rsp_valid, req_ready_b, rsp_valid_b;
  logic [W-1:0] mul_x, mul_y, mul_res, rsp_data;
  logic [W-1:0] mul_x_b, mul_y_b, mul_res_b, rsp_data_b;
  logic         busy, busy_b;
  logic [15:0]  op_count;
  logic [3:0]   op_count_b;

  assign mul_res   = mul_x * mul_y;
  assign mul_res_b = mul_x_b * mul_y_b;

  mult_arbiter #(.NUM_REQ(N), .DATA_W(W), .COUNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .mul_x(mul_x), .mul_y(mul_y),
    .mul_result(mul_res), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .busy(busy), .op_count(op_count));

  mult_arbiter #(.NUM_REQ(N), .DATA_W(W), .COUNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_b),
    .req_x(req_x), .req_y(req_y), .mul_x(mul_x_b), .mul_y(mul_y_b),
    .mul_result(mul_res_b), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data_b), .busy(busy_b), .op_count(op_count_b));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_lane(input int l, input logic [W-1:0] x, input logic [W-1:0] y);
    req_x[l*W +: W] = x;
    req_y[l*W +: W] = y;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  typedef struct {
    int           lane;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] prod;
  } vec_t;

  vec_t vt[6];

  initial begin
    vt[0] = '{0, 32'd3,          32'd5,          32'd15};
    vt[1] = '{1, 32'd7,          32'd6,          32'd42};
    vt[2] = '{2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001};
    vt[3] = '{3, 32'h0001_0000,  32'h0001_0000,  32'h0000_0000};
    vt[4] = '{0, 32'h0000_1234,  32'h0000_1000,  32'h0123_4000};
    vt[5] = '{3, 32'h0000_0000,  32'hDEAD_BEEF,  32'h0000_0000};

    // Reset state
    rst = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data",  rsp_data, 0);
    chk("rst_mul_x",     mul_x, 0);
    chk("rst_mul_y",     mul_y, 0);
    chk("rst_busy",      busy, 0);
    chk("rst_op_count",  op_count, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy",      busy, 0);
      chk("idle_req_ready", req_ready, 0);
    end

    // Single-transaction vector table
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      set_lane(vt[i].lane, vt[i].x, vt[i].y);
      req_valid = 4'b1 << vt[i].lane;
      rsp_ready = 4'hF;
      @(negedge clk);
      chk("vec_accept", req_ready, 4'b1 << vt[i].lane);
      chk("vec_busy0",  busy, 0);
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk);
      chk("vec_calc_busy", busy, 1);
      chk("vec_mul_x",     mul_x, vt[i].x);
      chk("vec_calc_rsp",  rsp_valid, 0);
      @(negedge clk);
      chk("vec_rsp_valid", rsp_valid, 4'b1 << vt[i].lane);
      chk("vec_rsp_data",  rsp_data, vt[i].prod);
      chk("vec_rsp_rdy0",  req_ready, 0);
      @(negedge clk);
      chk("vec_done_busy", busy, 0);
      chk("vec_op_count",  op_count, i + 1);
    end

    // All lanes requesting: rotation 0,1,2,3,0
    do_reset();
    for (int l = 0; l < N; l++) set_lane(l, l + 2, l + 10);
    req_valid = 4'hF;
    rsp_ready = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rot_accept", req_ready, 4'b1 << (k % N));
      @(negedge clk);
      @(negedge clk);
      chk("rot_rsp_valid", rsp_valid, 4'b1 << (k % N));
      chk("rot_rsp_data",  rsp_data, ((k % N) + 2) * ((k % N) + 10));
    end

    // Response back-pressure
    do_reset();
    set_lane(1, 32'd7, 32'd6);
    req_valid = 4'b0010;
    rsp_ready = 4'b0001;
    @(negedge clk);
    chk("bp_accept", req_ready, 4'b0010);
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk); #1 req_valid = 4'hF;
    repeat (5) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 4'b0010);
      chk("bp_rsp_data",  rsp_data, 42);
      chk("bp_req_ready", req_ready, 0);
    end
    @(posedge clk); #1 rsp_ready = 4'b0010;
    @(negedge clk);
    chk("bp_last_rsp", rsp_valid, 4'b0010);
    @(negedge clk);
    chk("bp_op_count",  op_count, 1);
    chk("bp_next_rr",   req_ready, 4'b0100);

    // Reset during CALC discards the transaction
    do_reset();
    set_lane(2, 32'd9, 32'd9);
    set_lane(0, 32'd4, 32'd4);
    req_valid = 4'b0100;
    rsp_ready = 4'hF;
    @(negedge clk);
    chk("mr_accept", req_ready, 4'b0100);
    @(posedge clk); #1;
    chk("mr_in_calc", busy, 1);
    rst = 1'b1;
    req_valid = 4'b0101;
    @(negedge clk);
    chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_busy",      busy, 0);
    chk("mr_req_ready", req_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mr_restart",   req_ready, 4'b0001);
    chk("mr_no_rsp",    rsp_valid, 0);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk); @(negedge clk);
    chk("mr_rsp_data",  rsp_data, 16);

    // Counter wrap at COUNT_W=4 after 17 ops
    do_reset();
    set_lane(0, 32'd2, 32'd3);
    req_valid = 4'b0001;
    rsp_ready = 4'hF;
    repeat (51) @(posedge clk);
    @(negedge clk);
    chk("wrap_count16", op_count, 17);
    chk("wrap_count4",  op_count_b, 1);

    // Random traffic vs. transaction-level model
    do_reset();
    begin
      int           last = N - 1;
      bit           pending = 0;
      int           plane = 0;
      int           age = 0;
      int           cnt = 0;
      int           w;
      logic [W-1:0] pval = '0;
      logic [W-1:0] xw, yw;
      for (int c = 0; c < 800; c++) begin
        if (c != 0) begin @(posedge clk); #1; end
        req_valid = N'($urandom_range(0, 15));
        rsp_ready = N'($urandom);
        for (int l = 0; l < N; l++)
          set_lane(l, ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom),
                      W'($urandom));
        @(negedge clk);
        if (!pending) begin
          chk("rnd_idle_rsp", rsp_valid, 0);
          if (req_valid != 0) begin
            w = rr_pick(last, req_valid);
            chk("rnd_grant", req_ready, 4'b1 << w);
            xw = req_x[w*W +: W];
            yw = req_y[w*W +: W];
            pval    = xw * yw;
            plane   = w;
            last    = w;
            pending = 1;
            age     = 0;
          end else begin
            chk("rnd_no_grant", req_ready, 0);
          end
        end else begin
          age++;
          chk("rnd_busy_rdy", req_ready, 0);
          if (age == 1) begin
            chk("rnd_calc_rsp", rsp_valid, 0);
          end else begin
            chk("rnd_rsp_valid", rsp_valid, 4'b1 << plane);
            chk("rnd_rsp_data",  rsp_data, pval);
            if (rsp_ready[plane]) begin
              pending = 0;
              cnt++;
            end
          end
        end
        chk("rnd_count16", op_count, cnt - ((pending == 0 && age >= 2 && rsp_ready[plane]) ? 1 : 0));
        chk("rnd_count4",  op_count_b, (cnt - ((pending == 0 && age >= 2 && rsp_ready[plane]) ? 1 : 0)) % 16);
        if (pending == 0) age = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
